// File: rtl/spmm_pkg.sv
// Shared constants and types for the rhs column streamer.
package spmm_pkg;

  localparam int unsigned N     = 16;
  localparam int unsigned W     = 8;
  localparam int unsigned LGN   = $clog2(N);
  localparam int unsigned BEATS = N / 4;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef logic [W-1:0] data_t;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_LOADING,
    BANK_FULL,
    BANK_STREAMING
  } bank_state_e;

endpackage

// File: rtl/rhs_bank.sv
// One rhs matrix bank: N x N storage written four rows per beat, a column
// read mux, and the bank lifecycle (state, held flag, age bit).
module rhs_bank
  import spmm_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [BW-1:0]           wr_beat,
  input  logic [3:0][N-1:0][W-1:0] wr_rows,
  input  logic                    load_start,
  input  logic                    load_done,
  input  logic                    other_done,
  input  logic                    stream_start,
  input  logic                    stream_hold,
  input  logic                    stream_end,
  input  logic [LGN-1:0]          rd_col,
  output bank_state_e             state,
  output logic                    old,
  output logic [N-1:0][W-1:0]     col_out
);

  data_t [N-1:0][N-1:0] mem;  // mem[row][col]
  logic [LGN-1:0]       base;
  bank_state_e          state_n;
  logic                 held, held_n, old_n;

  assign base = LGN'(wr_beat) << 2;

  // Storage: each beat writes rows 4k..4k+3.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem <= '0;
    end else if (wr_en) begin
      for (int unsigned r = 0; r < 4; r++) begin
        mem[base + LGN'(r)] <= wr_rows[r];
      end
    end
  end

  // Column read: element i of the vector is row i of column rd_col.
  always_comb begin
    col_out = '0;
    for (int unsigned i = 0; i < N; i++) begin
      col_out[i] = mem[i][rd_col];
    end
  end

  // Lifecycle registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= BANK_EMPTY;
      held  <= 1'b0;
      old   <= 1'b0;
    end else begin
      state <= state_n;
      held  <= held_n;
      old   <= old_n;
    end
  end

  // Next lifecycle state. A load completing in the other bank supersedes any
  // hold here, including one latched on the very same edge.
  always_comb begin
    state_n = state;
    held_n  = held;
    old_n   = old;
    if (load_done) begin
      old_n = 1'b0;
    end else if (other_done) begin
      old_n = 1'b1;
    end
    if (other_done) begin
      held_n = 1'b0;
    end
    case (state)
      BANK_EMPTY: begin
        if (load_start) begin
          state_n = load_done ? BANK_FULL : BANK_LOADING;
        end
      end
      BANK_LOADING: begin
        if (load_done) begin
          state_n = BANK_FULL;
        end
      end
      BANK_FULL: begin
        if (stream_start) begin
          state_n = BANK_STREAMING;
          held_n  = stream_hold && !other_done;
        end else if (other_done && held) begin
          state_n = BANK_EMPTY;
        end
      end
      BANK_STREAMING: begin
        if (stream_end) begin
          state_n = (held && !other_done) ? BANK_FULL : BANK_EMPTY;
        end
      end
      default: state_n = BANK_EMPTY;
    endcase
  end

endmodule

// File: rtl/rhs_col_streamer.sv
// Double-buffered rhs feeder: loads an N x N matrix in N/4 beats and streams
// it to the PE one column per cycle, with optional weight-stationary hold.
module rhs_col_streamer
  import spmm_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  output logic                     in_ready,
  input  logic                     in_start,
  input  logic [3:0][N-1:0][W-1:0] in_data,
  output logic                     col_ready,
  input  logic                     col_start,
  input  logic                     hold,
  output logic                     col_valid,
  output logic [LGN-1:0]           col_idx,
  output logic [N-1:0][W-1:0]      col_data,
  output logic                     col_last
);

  bank_state_e            bst  [2];
  logic                   bold [2];
  logic [N-1:0][W-1:0]    bcol [2];
  logic [1:0]             loading, empty, full, streaming;
  logic [1:0]             wr_en, load_start, load_done, stream_start, stream_end;
  logic [BW-1:0]          beat_cnt, wr_beat;
  logic                   last_beat, load_acc, load_tgt, col_acc, stream_tgt, sbank;
  logic [LGN-1:0]         rd_col;
  logic [N-1:0][W-1:0]    rd_data;

  // Bank arbitration and per-bank command decode.
  always_comb begin
    for (int unsigned b = 0; b < 2; b++) begin
      loading[b]   = (bst[b] == BANK_LOADING);
      empty[b]     = (bst[b] == BANK_EMPTY);
      full[b]      = (bst[b] == BANK_FULL);
      streaming[b] = (bst[b] == BANK_STREAMING);
    end
    in_ready   = !(|loading) && (|empty);
    col_ready  = (|full) && !(|streaming);
    load_acc   = in_start && in_ready;
    load_tgt   = !empty[0];
    col_acc    = col_start && col_ready;
    stream_tgt = (full[0] && full[1]) ? bold[1] : full[1];
    last_beat  = (beat_cnt == BW'(BEATS - 1));
    wr_beat    = load_acc ? '0 : beat_cnt;
    load_start = {2{load_acc}} & (load_tgt ? 2'b10 : 2'b01);
    wr_en      = load_start | loading;
    load_done  = (BEATS == 1) ? load_start : (loading & {2{last_beat}});
    stream_start = {2{col_acc}} & (stream_tgt ? 2'b10 : 2'b01);
    stream_end   = {2{col_valid && col_last}} & (sbank ? 2'b10 : 2'b01);
    rd_col     = col_acc ? '0 : col_idx + 1'b1;
    rd_data    = bcol[col_acc ? stream_tgt : sbank];
  end

  // Load beat counter; only one bank can be loading at a time.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat_cnt <= '0;
    end else if (load_acc) begin
      beat_cnt <= BW'(1);
    end else if (|loading) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

  // Stream column counter and registered column outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sbank     <= 1'b0;
      col_valid <= 1'b0;
      col_idx   <= '0;
      col_data  <= '0;
      col_last  <= 1'b0;
    end else if (col_acc) begin
      sbank     <= stream_tgt;
      col_valid <= 1'b1;
      col_idx   <= '0;
      col_data  <= rd_data;
      col_last  <= 1'b0;
    end else if (col_valid) begin
      if (col_last) begin
        col_valid <= 1'b0;
        col_idx   <= '0;
        col_data  <= '0;
        col_last  <= 1'b0;
      end else begin
        col_idx   <= rd_col;
        col_data  <= rd_data;
        col_last  <= (col_idx == LGN'(N - 2));
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    rhs_bank u_bank (
      .clock        (clock),
      .reset        (reset),
      .wr_en        (wr_en[b]),
      .wr_beat      (wr_beat),
      .wr_rows      (in_data),
      .load_start   (load_start[b]),
      .load_done    (load_done[b]),
      .other_done   (load_done[1-b]),
      .stream_start (stream_start[b]),
      .stream_hold  (hold),
      .stream_end   (stream_end[b]),
      .rd_col       (rd_col),
      .state        (bst[b]),
      .old          (bold[b]),
      .col_out      (bcol[b])
    );
  end

endmodule
